// File: rtl/md_sched.sv
// Multiply/divide scheduler and HI/LO owner beside the E-stage ALU.
// Fixed-latency busy counter per operation; results commit to HI/LO as the count expires.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use,
  input  logic        hl_sel,
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] HL
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  logic [3:0]  cnt;
  logic [2:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] hi_q, lo_q;

  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur;
  logic [31:0] res_hi, res_lo;

  // Signed divide is done on magnitudes so 0x80000000 / -1 naturally yields 0x80000000, rem 0.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    uq     = 32'd0;
    ur     = 32'd0;
    res_hi = hi_q;
    res_lo = lo_q;
    case (op_q)
      OP_MULT: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      OP_MULTU: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      OP_DIV: begin
        if (b_q != 32'd0) begin
          uq     = abs_a / abs_b;
          ur     = abs_a % abs_b;
          res_lo = (a_q[31] ^ b_q[31]) ? (~uq + 32'd1) : uq;
          res_hi = a_q[31] ? (~ur + 32'd1) : ur;
        end
      end
      OP_DIVU: begin
        if (b_q != 32'd0) begin
          res_lo = a_q / b_q;
          res_hi = a_q % b_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 4'd0;
      op_q <= 3'd0;
      a_q  <= 32'd0;
      b_q  <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
          a_q  <= A;
          b_q  <= B;
          op_q <= md_op;
          cnt  <= (md_op == OP_MULT || md_op == OP_MULTU) ? MULT_N : DIV_N;
        end
        OP_MTHI: hi_q <= A;
        OP_MTLO: lo_q <= A;
        default: ;
      endcase
    end
  end

  assign busy  = (cnt != 4'd0);
  assign stall = md_use & busy;
  assign HI    = hi_q;
  assign LO    = lo_q;
  assign HL    = hl_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_md_sched.sv
// Directed bench for md_sched: inputs change on the falling edge, outputs are checked there too.
module tb_md_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] A, B;
  logic        md_use;
  logic        hl_sel;
  logic        busy, stall;
  logic [31:0] HI, LO, HL;

  int total = 0;
  int bad   = 0;

  md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .rst(rst), .start(start), .md_op(md_op), .A(A), .B(B),
    .md_use(md_use), .hl_sel(hl_sel), .busy(busy), .stall(stall),
    .HI(HI), .LO(LO), .HL(HL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one timed op, scramble the operand inputs, check n busy/stall cycles then the commit.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; md_op = op; A = a; B = b;
    #1 chk({tag, " issue stall"}, {31'b0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; A = 32'hDEAD_BEEF; B = 32'hCAFE_F00D;
    for (int i = 0; i < n; i++) begin
      chk({tag, " busy"},  {31'b0, busy},  32'd1);
      chk({tag, " stall"}, {31'b0, stall}, 32'd1);
      @(negedge clk);
    end
    chk({tag, " busy end"},  {31'b0, busy},  32'd0);
    chk({tag, " stall end"}, {31'b0, stall}, 32'd0);
    chk({tag, " HI"}, HI, eh);
    chk({tag, " LO"}, LO, el);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; md_op = 3'd0; A = 32'd0; B = 32'd0;
    md_use = 1'b1; hl_sel = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("reset HI", HI, 32'd0);
    chk("reset LO", LO, 32'd0);
    chk("reset busy", {31'b0, busy}, 32'd0);
    chk("reset stall", {31'b0, stall}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Preset HI/LO, then abort a DIV by reset at count 4.
    start = 1'b1; md_op = 3'd5; A = 32'h11;
    @(negedge clk);
    chk("mthi HI", HI, 32'h11);
    md_op = 3'd6; A = 32'h22;
    @(negedge clk);
    chk("mtlo LO", LO, 32'h22);
    chk("mtlo HL lo", HL, 32'h22);
    start = 1'b1; md_op = 3'd3; A = 32'd100; B = 32'd7;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("abort busy", {31'b0, busy}, 32'd1);
    repeat (6) @(negedge clk);
    chk("abort busy c4", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("abort async busy", {31'b0, busy}, 32'd0);
    chk("abort async HI", HI, 32'd0);
    chk("abort async LO", LO, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort no commit HI", HI, 32'd0);
    chk("abort no commit LO", LO, 32'd0);
    chk("abort idle busy", {31'b0, busy}, 32'd0);

    run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div negb", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'd1, 32'hFFFF_FFFD);
    run_op("div ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000);
    run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);

    // Divide by zero leaves preset values alone.
    start = 1'b1; md_op = 3'd5; A = 32'h11;
    @(negedge clk);
    md_op = 3'd6; A = 32'h22;
    @(negedge clk);
    start = 1'b0;
    run_op("divu0", 3'd4, 32'd7, 32'd0, 10, 32'h11, 32'h22);
    run_op("div0", 3'd3, 32'hFFFF_FFF9, 32'd0, 10, 32'h11, 32'h22);

    // Second start on cycle 2 of a MULT must be ignored.
    start = 1'b1; md_op = 3'd1; A = 32'd3; B = 32'd5;
    @(negedge clk);
    chk("ign busy1", {31'b0, busy}, 32'd1);
    start = 1'b1; md_op = 3'd1; A = 32'd1; B = 32'd1;
    @(negedge clk);
    chk("ign busy2", {31'b0, busy}, 32'd1);
    start = 1'b0; md_op = 3'd0;
    repeat (3) begin
      @(negedge clk);
      chk("ign busy n", {31'b0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("ign busy end", {31'b0, busy}, 32'd0);
    chk("ign HI", HI, 32'd0);
    chk("ign LO", LO, 32'd15);

    // MTHI at idle.
    hl_sel = 1'b1;
    start = 1'b1; md_op = 3'd5; A = 32'h1234;
    #1 chk("mthi2 pre busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; A = 32'd0;
    chk("mthi2 HI", HI, 32'h1234);
    chk("mthi2 HL", HL, 32'h1234);
    chk("mthi2 busy", {31'b0, busy}, 32'd0);
    chk("mthi2 LO kept", LO, 32'd15);
    @(negedge clk);
    chk("mthi2 busy later", {31'b0, busy}, 32'd0);
    hl_sel = 1'b0;
    #1 chk("HL lo sel", HL, 32'd15);

    // Op 7 is a no-op.
    start = 1'b1; md_op = 3'd7; A = 32'h5555;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    chk("op7 busy", {31'b0, busy}, 32'd0);
    chk("op7 HI", HI, 32'h1234);
    chk("op7 LO", LO, 32'd15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
